playbus_sequencer: RTL and testbench
====================================

PLAYBUS_SEQUENCER -- requirements
Module: playbus_sequencer

Interface
REQ-001 Parameter FUNC_W, default 3: width of the func opcode; codes above 6 are reserved.
REQ-002 Parameter WAIT_STATES, default 0, range 0..15: extra access cycles held before the destination strobe.
REQ-003 Parameter NUM_LED, default 1, range 1..8: number of independently latched LED output ports.
REQ-004 Parameter SEL_W, default $clog2(NUM_LED) with minimum 1: width of led_sel.
REQ-005 clk  input  1  single system clock; all state changes on the rising edge.
REQ-006 n_reset  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  request pulse; sampled only in IDLE.
REQ-008 func  input  FUNC_W  opcode, captured with start.
REQ-009 led_sel  input  SEL_W  LED port index, captured with start.
REQ-010 ROMO, RAMO, SWBEN  output  1  bus source enables (ROM, RAM, switch buffer).
REQ-011 RAMW  output  1  RAM write strobe.
REQ-012 LEDLTCH  output  NUM_LED  per-port LED latch strobes.
REQ-013 busy  output  1  high from the cycle after start is accepted until DONE is exited.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  one-cycle pulse coincident with done for a reserved opcode or an out-of-range led_sel.

Function
REQ-016 Opcodes: 0 NOP; 1 ROM->LED; 2 SW read (source only); 3 RAM->LED; 4 SW->RAM; 5 SW->LED; 6 ROM->RAM.
REQ-017 States: IDLE, SETUP, ACCESS, XFER, DONE.
REQ-018 IDLE with start=1 and a valid source opcode (1..6) SHALL capture func and led_sel and go to SETUP.
REQ-019 IDLE with start=1 and opcode 0 or a reserved opcode SHALL go directly to DONE; err SHALL be 1 only for a reserved opcode.
REQ-020 SETUP lasts 1 cycle and SHALL assert the source enable (ROMO, RAMO or SWBEN) of the captured opcode.
REQ-021 ACCESS SHALL last exactly WAIT_STATES cycles, with the source enable held. When WAIT_STATES=0, SETUP goes straight to XFER.
REQ-022 XFER lasts 1 cycle, with the source enable held, and SHALL assert the destination strobe for exactly that cycle:
- LED destination: LEDLTCH[led_sel].
- RAM destination: RAMW.
- Opcode 2: no destination strobe.
REQ-023 DONE lasts 1 cycle with all strobes low and done=1, then SHALL return to IDLE.
REQ-024 A valid opcode gives start-to-done latency of 3+WAIT_STATES edges; NOP or reserved gives 1 edge.
REQ-025 At most one of ROMO, RAMO, SWBEN SHALL be high in any cycle, and LEDLTCH SHALL be one-hot or zero.
REQ-026 An out-of-range led_sel on an LED opcode SHALL run the full sequence with no LEDLTCH bit asserted and err=1 in DONE.
REQ-027 start while busy, or while in DONE, SHALL be ignored and SHALL NOT be queued.
REQ-028 Changes to func or led_sel after capture SHALL NOT affect the transfer in progress.
REQ-029 All outputs SHALL be decoded from registered state and captured values only, with no combinational path from start, func or led_sel.

Reset
REQ-030 While n_reset=0, the block SHALL be in IDLE, with the captured fields and the wait counter cleared.
REQ-031 While n_reset=0, every output (ROMO, RAMO, RAMW, SWBEN, LEDLTCH, busy, done, err) SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL drop all strobes immediately (asynchronously), and the aborted transfer SHALL NOT produce done.
REQ-033 The first start SHALL be accepted on the first rising edge after n_reset deasserts.

Structure
REQ-034 The state enum and the opcode enum SHALL live in shared package playbus_pkg, together with the constants for the reserved-opcode boundary and the maximum WAIT_STATES.
REQ-035 The wait-state down-counter SHALL be a sub-module, wait_counter, with load, count-enable and zero-flag ports.

Verification
REQ-036 WAIT_STATES=2, NUM_LED=4, func=5, sel=2, start at edge 0 -> SWBEN high for cycles 1..4, LEDLTCH=4'b0100 in cycle 4 only, done at cycle 5.
REQ-037 WAIT_STATES=0, func=4 -> SWBEN high for 2 cycles, RAMW high only in the 2nd cycle, done in the 3rd, busy high for 3 cycles.
REQ-038 func=7 -> done=1 and err=1 at edge 1, no strobe at any time; func=0 -> done=1 and err=0.
REQ-039 NUM_LED=3, func=1, sel=3 -> ROMO runs the full sequence, LEDLTCH stays 0, err=1 with done.
REQ-040 start held high continuously with func=3 -> back-to-back transfers separated by exactly 1 IDLE cycle, none skipped or doubled.
REQ-041 n_reset pulled low during ACCESS -> all outputs 0 in the same cycle, no done; next start completes normally.

Source files
------------

// File: rtl/playbus_pkg.sv
// rtl/playbus_pkg.sv - shared state/opcode types, constants and decode helpers for playbus_sequencer
package playbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_XFER   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // OP_RSVD stands in for every code at or above OP_RESERVED_MIN once captured
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_ROM_LED = 3'd1,
        OP_SW_READ = 3'd2,
        OP_RAM_LED = 3'd3,
        OP_SW_RAM  = 3'd4,
        OP_SW_LED  = 3'd5,
        OP_ROM_RAM = 3'd6,
        OP_RSVD    = 3'd7
    } opcode_t;

    localparam int OP_RESERVED_MIN = 7;
    localparam int MAX_WAIT_STATES = 15;
    localparam int WAIT_CNT_W      = 4;

    // Fold an arbitrary-width opcode into the enum; anything too large becomes OP_RSVD
    function automatic opcode_t to_opcode(input logic [31:0] code);
        if (code >= 32'(OP_RESERVED_MIN)) begin
            return OP_RSVD;
        end
        return opcode_t'(code[2:0]);
    endfunction

    function automatic logic is_transfer(input opcode_t op);
        return (op != OP_NOP) && (op != OP_RSVD);
    endfunction

    function automatic logic src_rom(input opcode_t op);
        return (op == OP_ROM_LED) || (op == OP_ROM_RAM);
    endfunction

    function automatic logic src_ram(input opcode_t op);
        return (op == OP_RAM_LED);
    endfunction

    function automatic logic src_sw(input opcode_t op);
        return (op == OP_SW_READ) || (op == OP_SW_RAM) || (op == OP_SW_LED);
    endfunction

    function automatic logic dst_led(input opcode_t op);
        return (op == OP_ROM_LED) || (op == OP_RAM_LED) || (op == OP_SW_LED);
    endfunction

    function automatic logic dst_ram(input opcode_t op);
        return (op == OP_SW_RAM) || (op == OP_ROM_RAM);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - loadable wait-state down-counter with zero flag
module wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             count_en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load wins over counting; the count parks at zero rather than wrapping
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/playbus_sequencer.sv
// rtl/playbus_sequencer.sv - bus transfer sequencer driving source enables and destination strobes
module playbus_sequencer
    import playbus_pkg::*;
#(
    parameter int FUNC_W      = 3,
    parameter int WAIT_STATES = 0,
    parameter int NUM_LED     = 1,
    parameter int SEL_W       = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               start,
    input  logic [FUNC_W-1:0]  func,
    input  logic [SEL_W-1:0]   led_sel,
    output logic               ROMO,
    output logic               RAMO,
    output logic               SWBEN,
    output logic               RAMW,
    output logic [NUM_LED-1:0] LEDLTCH,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // ACCESS runs WAIT_STATES cycles, so the counter is preloaded with one less
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_t           state;
    state_t           state_next;
    opcode_t          op_q;
    opcode_t          op_in;
    logic [SEL_W-1:0] sel_q;
    logic [31:0]      sel_ext;
    logic             sel_ok;
    logic             accept;
    logic             wait_load;
    logic             wait_en;
    logic             wait_zero;
    logic             src_phase;
    logic             xfer_phase;

    assign op_in   = to_opcode(32'(func));
    assign accept  = (state == ST_IDLE) && start;
    assign sel_ext = 32'(sel_q);
    assign sel_ok  = (sel_ext < 32'(NUM_LED));

    wait_counter #(
        .CNT_W(WAIT_CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .n_reset    (n_reset),
        .load       (wait_load),
        .load_value (WAIT_LOAD),
        .count_en   (wait_en),
        .zero       (wait_zero)
    );

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture opcode and LED index once at acceptance so later input changes are ignored
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            op_q  <= OP_NOP;
            sel_q <= '0;
        end else if (accept) begin
            op_q  <= op_in;
            sel_q <= led_sel;
        end
    end

    // Next-state and wait-counter control
    always_comb begin
        state_next = state;
        wait_load  = 1'b0;
        wait_en    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = is_transfer(op_in) ? ST_SETUP : ST_DONE;
                end
            end
            ST_SETUP: begin
                wait_load  = 1'b1;
                state_next = (WAIT_STATES == 0) ? ST_XFER : ST_ACCESS;
            end
            ST_ACCESS: begin
                wait_en = 1'b1;
                if (wait_zero) begin
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state and captured fields only
    always_comb begin
        src_phase  = (state == ST_SETUP) || (state == ST_ACCESS) || (state == ST_XFER);
        xfer_phase = (state == ST_XFER);
        ROMO       = src_phase && src_rom(op_q);
        RAMO       = src_phase && src_ram(op_q);
        SWBEN      = src_phase && src_sw(op_q);
        RAMW       = xfer_phase && dst_ram(op_q);
        LEDLTCH    = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            LEDLTCH[i] = xfer_phase && dst_led(op_q) && (sel_ext == 32'(i));
        end
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
        err  = (state == ST_DONE) && ((op_q == OP_RSVD) || (dst_led(op_q) && !sel_ok));
    end

endmodule

// File: tb/tb_playbus_sequencer.sv
// tb/tb_playbus_sequencer.sv - self-checking bench for playbus_sequencer at two parameter sets
module tb_playbus_sequencer;

    localparam int WS_A = 2;
    localparam int NL_A = 4;
    localparam int WS_B = 0;
    localparam int NL_B = 3;

    typedef struct packed {
        logic       romo;
        logic       ramo;
        logic       swben;
        logic       ramw;
        logic [7:0] led;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    // src: 0 none, 1 ROM, 2 RAM, 3 SW ; dst: 0 none, 1 LED, 2 RAM
    typedef struct {
        logic [2:0] func;
        logic [1:0] sel;
        int         src;
        int         dst;
        logic       err_a;
        logic       err_b;
    } vec_t;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       start;
    logic [2:0] func;
    logic [1:0] led_sel;

    logic       romo_a, ramo_a, swben_a, ramw_a, busy_a, done_a, err_a;
    logic [3:0] led_a;
    logic       romo_b, ramo_b, swben_b, ramw_b, busy_b, done_b, err_b;
    logic [2:0] led_b;
    obs_t       obs_a, obs_b;

    obs_t q_a[$];
    obs_t q_b[$];
    vec_t vecs[12];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    playbus_sequencer #(.FUNC_W(3), .WAIT_STATES(WS_A), .NUM_LED(NL_A)) dut_a (
        .clk(clk), .n_reset(n_reset), .start(start), .func(func), .led_sel(led_sel),
        .ROMO(romo_a), .RAMO(ramo_a), .SWBEN(swben_a), .RAMW(ramw_a), .LEDLTCH(led_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    playbus_sequencer #(.FUNC_W(3), .WAIT_STATES(WS_B), .NUM_LED(NL_B)) dut_b (
        .clk(clk), .n_reset(n_reset), .start(start), .func(func), .led_sel(led_sel),
        .ROMO(romo_b), .RAMO(ramo_b), .SWBEN(swben_b), .RAMW(ramw_b), .LEDLTCH(led_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    assign obs_a = {romo_a, ramo_a, swben_a, ramw_a, 4'b0, led_a, busy_a, done_a, err_a};
    assign obs_b = {romo_b, ramo_b, swben_b, ramw_b, 5'b0, led_b, busy_b, done_b, err_b};

    task automatic push_obs(input int which, input obs_t o);
        if (which == 0) q_a.push_back(o);
        else            q_b.push_back(o);
    endtask

    // Expected per-cycle trace of one accepted request, starting with the cycle after the accepting edge
    task automatic push_trace(input int which, input int ws, input int nl, input vec_t v, input logic e);
        obs_t o;
        o = '0;
        if (v.src == 0) begin
            o.busy = 1'b1; o.done = 1'b1; o.err = e;
            push_obs(which, o);
        end else begin
            o.busy  = 1'b1;
            o.romo  = (v.src == 1);
            o.ramo  = (v.src == 2);
            o.swben = (v.src == 3);
            push_obs(which, o);
            for (int i = 0; i < ws; i++) push_obs(which, o);
            if (v.dst == 1 && int'(v.sel) < nl) o.led = 8'b1 << v.sel;
            if (v.dst == 2) o.ramw = 1'b1;
            push_obs(which, o);
            o = '0;
            o.busy = 1'b1; o.done = 1'b1; o.err = e;
            push_obs(which, o);
        end
    endtask

    task automatic push_both(input vec_t v);
        push_trace(0, WS_A, NL_A, v, v.err_a);
        push_trace(1, WS_B, NL_B, v, v.err_b);
    endtask

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_cycle(input string tag);
        obs_t ea, eb;
        ea = (q_a.size() > 0) ? q_a.pop_front() : '0;
        eb = (q_b.size() > 0) ? q_b.pop_front() : '0;
        compare({tag, "_a"}, obs_a, ea);
        compare({tag, "_b"}, obs_b, eb);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_cycle(tag);
    endtask

    // One start pulse, then scramble func/led_sel while the transfer runs, drain, confirm idle
    task automatic run_vec(input vec_t v, input string tag);
        start   = 1'b1;
        func    = v.func;
        led_sel = v.sel;
        push_both(v);
        step(tag);
        start   = 1'b0;
        func    = 3'($urandom);
        led_sel = 2'($urandom);
        for (int c = 0; c < 40 && (q_a.size() > 0 || q_b.size() > 0); c++) step(tag);
        step({tag, "_idle"});
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{3'd5, 2'd2, 3, 1, 1'b0, 1'b0};
        vecs[1]  = '{3'd4, 2'd0, 3, 2, 1'b0, 1'b0};
        vecs[2]  = '{3'd7, 2'd0, 0, 0, 1'b1, 1'b1};
        vecs[3]  = '{3'd0, 2'd0, 0, 0, 1'b0, 1'b0};
        vecs[4]  = '{3'd1, 2'd3, 1, 1, 1'b0, 1'b1};
        vecs[5]  = '{3'd3, 2'd1, 2, 1, 1'b0, 1'b0};
        vecs[6]  = '{3'd2, 2'd3, 3, 0, 1'b0, 1'b0};
        vecs[7]  = '{3'd6, 2'd1, 1, 2, 1'b0, 1'b0};
        vecs[8]  = '{3'd1, 2'd0, 1, 1, 1'b0, 1'b0};
        vecs[9]  = '{3'd3, 2'd3, 2, 1, 1'b0, 1'b1};
        vecs[10] = '{3'd5, 2'd3, 3, 1, 1'b0, 1'b1};
        vecs[11] = '{3'd6, 2'd3, 1, 2, 1'b0, 1'b0};

        n_reset = 1'b0;
        start   = 1'b0;
        func    = 3'd0;
        led_sel = 2'd0;
        #1;
        check_cycle("reset_t0");

        start   = 1'b1;
        func    = 3'd5;
        led_sel = 2'd2;
        for (int i = 0; i < 3; i++) step("reset_hold");

        n_reset = 1'b1;
        run_vec(vecs[0], "first_after_reset");

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // start held high: A repeats every 6 cycles, B every 4; 12 edges give 2 and 3 transfers
        v = '{3'd3, 2'd1, 2, 1, 1'b0, 1'b0};
        start   = 1'b1;
        func    = v.func;
        led_sel = v.sel;
        for (int k = 0; k < 2; k++) begin
            push_trace(0, WS_A, NL_A, v, 1'b0);
            push_obs(0, '0);
        end
        for (int k = 0; k < 3; k++) begin
            push_trace(1, WS_B, NL_B, v, 1'b0);
            push_obs(1, '0);
        end
        for (int k = 0; k < 12; k++) step("b2b");
        start = 1'b0;
        step("b2b_end");

        // Reset mid-transfer: A is in ACCESS, B in XFER when n_reset falls between edges
        v = '{3'd5, 2'd0, 3, 1, 1'b0, 1'b0};
        start   = 1'b1;
        func    = v.func;
        led_sel = v.sel;
        push_both(v);
        step("abort_setup");
        start = 1'b0;
        step("abort_access");
        #2;
        n_reset = 1'b0;
        #1;
        q_a.delete();
        q_b.delete();
        check_cycle("abort_async");
        step("abort_hold");
        step("abort_hold");
        n_reset = 1'b1;
        step("abort_no_done");
        step("abort_no_done");
        run_vec(vecs[1], "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
